// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: bus widths, instruction field
// positions and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam int OPCODE_HI  = 7;
    localparam int OPCODE_LO  = 4;
    localparam int OPERAND_HI = 3;
    localparam int OPERAND_LO = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STOP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with synchronous increment and load; load has priority,
// increment wraps naturally at 2^W.
module pc_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_addr,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads the ROM at pc into the instruction
// register and hands it to the decoder over a valid/ready handshake.
//
// state    | meaning
// ST_FETCH | read rom_data at pc into IR (or stop if run is low)
// ST_HOLD  | IR valid, waiting for the decoder to accept it
// ST_STOP  | halted, pc frozen, waiting for run
module fetch_unit
    import cpu_pkg::fetch_state_e;
    import cpu_pkg::ST_FETCH;
    import cpu_pkg::ST_HOLD;
    import cpu_pkg::ST_STOP;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              halted
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic              load_ir;
    logic              clr_valid;
    logic              pc_inc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc;

    pc_reg #(
        .W (ADDR_W)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (jump_addr),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_ir   = 1'b0;
        clr_valid = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    load_ir = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_HOLD: begin
                // A jump is only honoured together with the transfer so the
                // decoder never sees an instruction from the redirected stream
                // before it has consumed the current one.
                if (instr_valid && instr_ready) begin
                    clr_valid = 1'b1;
                    pc_load   = jump_en;
                    state_d   = ST_FETCH;
                end
            end
            ST_STOP: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (load_ir) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (clr_valid) begin
            instr_valid <= 1'b0;
        end
    end

    assign rom_addr = pc;
    assign opcode   = instr[cpu_pkg::OPCODE_HI:cpu_pkg::OPCODE_LO];
    assign operand  = instr[cpu_pkg::OPERAND_HI:cpu_pkg::OPERAND_LO];
    assign halted   = (state_q == ST_STOP);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning program-memory address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction width: [7:4] opcode, [3:0] operand.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port run  input  1  fetch enable; low means stop at the next FETCH.
REQ-006 SHALL have port rom_addr  output  ADDR_W  address to program ROM, equal to pc.
REQ-007 SHALL have port rom_data  input  DATA_W  combinational ROM read data for rom_addr.
REQ-008 SHALL have port instr  output  DATA_W  registered instruction (IR).
REQ-009 SHALL have port opcode  output  4  instr[7:4].
REQ-010 SHALL have port operand  output  4  instr[3:0].
REQ-011 SHALL have port instr_pc  output  ADDR_W  address from which instr was fetched.
REQ-012 SHALL have port instr_valid  output  1  instr holds an unconsumed instruction.
REQ-013 SHALL have port instr_ready  input  1  decoder accepts instr this cycle.
REQ-014 SHALL have port jump_en  input  1  redirect request, qualified by the handshake.
REQ-015 SHALL have port jump_addr  input  ADDR_W  redirect target.
REQ-016 SHALL have port halted  output  1  unit is in STOP state.

Function
REQ-017 SHALL implement FSM states FETCH, HOLD and STOP, registered.
REQ-018 In FETCH with run=1, on the clock edge it SHALL load instr<=rom_data, instr_pc<=pc, instr_valid<=1 and pc<=pc+1 modulo 2^ADDR_W (15 -> 0 wraps), then go to HOLD.
REQ-019 In FETCH with run=0, it SHALL go to STOP with pc, instr and instr_valid unchanged.
REQ-020 In HOLD, instr, instr_pc and instr_valid SHALL stay stable until instr_valid and instr_ready are both 1 (transfer).
REQ-021 On transfer, it SHALL clear instr_valid and go to FETCH.
REQ-022 On transfer with jump_en=1, it SHALL also load pc<=jump_addr, which overrides the increment already applied.
REQ-023 jump_en without a transfer (HOLD with ready=0, or FETCH, or STOP) SHALL be ignored.
REQ-024 In STOP, halted SHALL be 1 and pc SHALL hold; on run=1 it SHALL go to FETCH on the next edge.
REQ-025 rom_addr SHALL equal pc combinationally in every state.
REQ-026 Throughput SHALL be one instruction per 2 cycles with instr_ready tied high; latency from entering FETCH to instr_valid=1 SHALL be 1 cycle.
REQ-027 opcode, operand and halted SHALL be combinational decodes of registered state only.

Reset
REQ-028 rst_n=0 SHALL asynchronously set pc=0, instr=8'h00, instr_pc=0, instr_valid=0 and state=FETCH, so halted=0.
REQ-029 Reset asserted mid-HOLD SHALL discard the pending instruction with no transfer.
REQ-030 After rst_n deasserts, the first fetch SHALL occur on the first edge with run=1.

Structure
REQ-031 A shared package cpu_pkg SHALL hold ADDR_W, DATA_W, the fetch state enum, and opcode/operand field slices.
REQ-032 The block SHALL be a single module; a sub-module pc_reg (pc with increment, load and wrap) is permitted.
REQ-033 ROM timing SHALL not be assumed beyond combinational rom_data within the same cycle.

Verification
REQ-034 Reset with run=1 and ready=1, ROM = {12,25,FC,3A,4F,51,73,AD,00...} -> instr 0x12, 0x25, 0xFC, 0x3A on every second cycle, with instr_pc 0,1,2,3.
REQ-035 Hold ready=0 for 5 cycles while instr=0x25 -> instr, instr_pc=1 and valid stay stable, and rom_addr stays 2.
REQ-036 Transfer of instr_pc=2 with jump_en=1 and jump_addr=5 -> next instr=0x51 with instr_pc=5.
REQ-037 Run through pc=15 -> instr_pc=15 is followed by instr_pc=0 with instr=0x12.
REQ-038 Drop run during HOLD -> after the transfer the unit enters STOP with halted=1 and pc frozen; raise run -> fetching resumes at the frozen pc.
REQ-039 Assert rst_n=0 asynchronously mid-HOLD -> instr_valid=0 immediately, and after release the first instr is 0x12.
